// File: rtl/seg7_scan_monitor_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_monitor_if
//   Bundle for a 4-digit multiplexed 7-segment display bus. All lines are
//   active-low.
//   an   [3:0]  anode enables, one-hot low while a digit is driven; an[0] is
//               the rightmost digit
//   seg  [6:0]  segments a..g, seg[6] = a ... seg[0] = g
//   dp          decimal point
//   Modports: master drives the bus (display driver), slave observes it
//   (scan monitor).
// ---------------------------------------------------------------------------
interface seg7_scan_monitor_if;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output an, seg, dp);
    modport slave  (input  an, seg, dp);
endinterface

// File: rtl/seg7_scan_monitor.sv
// ---------------------------------------------------------------------------
// seg7_scan_monitor
//   Watches a scanned 4-digit 7-segment bus and rebuilds the displayed hex
//   value, decimal-point mask and blank mask one full frame at a time.
//   Ports:
//     clk          system clock
//     reset_n      asynchronous, active-low reset
//     disp         display bus (slave modport: an, seg, dp)
//     value        last committed frame, an[k] digit -> value[4k+3:4k]
//     dp_mask      last committed decimal points (1 = lit)
//     blank_mask   last committed blank digits (1 = all segments off)
//     frame_valid  one-cycle pulse on each frame commit
//     value_chg    pulses with frame_valid when value changed (always on the
//                  first frame after reset)
//     digit_err    illegal segment pattern per digit of the last frame
//     proto_err    sticky: anodes seen multi-hot
//     stale        no frame committed for TIMEOUT_CYCLES cycles
// ---------------------------------------------------------------------------
module seg7_scan_monitor #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seg7_scan_monitor_if.slave   disp,
    output logic [15:0]          value,
    output logic [3:0]           dp_mask,
    output logic [3:0]           blank_mask,
    output logic                 frame_valid,
    output logic                 value_chg,
    output logic [3:0]           digit_err,
    output logic                 proto_err,
    output logic                 stale
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } bus_t;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } dec_t;

    // An undriven bus: no anode, no segment, no dp.
    localparam bus_t BUS_IDLE = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

    function automatic dec_t decode(input logic [6:0] pat);
        dec_t d;
        d = '{nib: 4'h0, blank: 1'b0, err: 1'b0};
        case (pat)
            7'h01: d.nib = 4'h0;
            7'h4F: d.nib = 4'h1;
            7'h12: d.nib = 4'h2;
            7'h06: d.nib = 4'h3;
            7'h4C: d.nib = 4'h4;
            7'h24: d.nib = 4'h5;
            7'h20: d.nib = 4'h6;
            7'h0F: d.nib = 4'h7;
            7'h00: d.nib = 4'h8;
            7'h04: d.nib = 4'h9;
            7'h08: d.nib = 4'hA;
            7'h60: d.nib = 4'hB;
            7'h31: d.nib = 4'hC;
            7'h42: d.nib = 4'hD;
            7'h30: d.nib = 4'hE;
            7'h38: d.nib = 4'hF;
            7'h7F: d.blank = 1'b1;
            default: d.err = 1'b1;
        endcase
        return d;
    endfunction

    bus_t          sync1, sync2, prev;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [3:0]    seen;
    logic [15:0]   stage_value;
    logic [3:0]    stage_dp, stage_blank, stage_err;
    logic          have_frame;

    logic [3:0]    act;
    logic          one_hot, multi_hot, changed, sample, commit;
    logic [1:0]    idx;
    dec_t          dec;

    // NOTE: the synchronizer resets to the idle bus, not to zero; an all-zero
    // anode vector would read as multi-hot and raise proto_err out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= BUS_IDLE;
            sync2 <= BUS_IDLE;
        end else begin
            sync1 <= '{an: disp.an, seg: disp.seg, dp: disp.dp};
            sync2 <= sync1;
        end
    end

    // NOTE: every variable driven here gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        act       = ~sync2.an;
        one_hot   = (act != 4'h0) && ((act & (act - 4'd1)) == 4'h0);
        multi_hot = (act != 4'h0) && !one_hot;
        changed   = (sync2 != prev);
        // Fires on the single cycle the counter steps into saturation, so a
        // long dwell yields exactly one sample.
        sample    = !changed && one_hot && (settle_cnt == SW'(SETTLE_CYCLES - 1));
        // Multi-hot in the same cycle as a complete frame suppresses the commit.
        commit    = (seen == 4'hF) && !multi_hot;
        dec       = decode(sync2.seg);
        idx       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (act[k]) idx = 2'(k);
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev        <= BUS_IDLE;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
            seen        <= 4'h0;
            stage_value <= 16'h0;
            stage_dp    <= 4'h0;
            stage_blank <= 4'h0;
            stage_err   <= 4'h0;
            have_frame  <= 1'b0;
            value       <= 16'h0;
            dp_mask     <= 4'h0;
            blank_mask  <= 4'h0;
            frame_valid <= 1'b0;
            value_chg   <= 1'b0;
            digit_err   <= 4'h0;
            proto_err   <= 1'b0;
            stale       <= 1'b0;
        end else begin
            prev        <= sync2;
            frame_valid <= 1'b0;
            value_chg   <= 1'b0;

            // A blanking gap restarts settling just like a change does.
            if (changed || sync2.an == 4'hF) begin
                settle_cnt <= '0;
            end else if (settle_cnt != SW'(SETTLE_CYCLES)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end

            if (sample) begin
                stage_value[4*idx +: 4] <= dec.nib;
                stage_dp[idx]           <= ~sync2.dp;
                stage_blank[idx]        <= dec.blank;
                stage_err[idx]          <= dec.err;
            end

            if (multi_hot) begin
                proto_err <= 1'b1;
                seen      <= 4'h0;
            end else begin
                if (commit) begin
                    value       <= stage_value;
                    dp_mask     <= stage_dp;
                    blank_mask  <= stage_blank;
                    digit_err   <= stage_err;
                    frame_valid <= 1'b1;
                    value_chg   <= !have_frame || (stage_value != value);
                    have_frame  <= 1'b1;
                end
                seen <= (commit ? 4'h0 : seen) | (sample ? act : 4'h0);
            end

            if (commit) begin
                timeout_cnt <= '0;
                stale       <= 1'b0;
            end else if (timeout_cnt != TW'(TIMEOUT_CYCLES)) begin
                timeout_cnt <= timeout_cnt + 1'b1;
                if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) stale <= 1'b1;
            end
        end
    end

endmodule
